seq_divider: RTL and testbench

- Iterative radix-2 restoring divider that services the execute stage's valid/data_ok request protocol.
- One instance handles signed and unsigned DIV/REM on 64-bit operands.
- The ALU holds valid high and stalls (bubble = ~data_ok) until this block raises data_ok, then captures quot/rem.
- Replaces separate signed/unsigned dividers; the ALU keeps its own b==0 result muxing, which stays consistent with this block's defined b==0 results.

---
 rtl/seq_divider.sv | 78 +++++++
 tb/tb_seq_divider.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, signed/unsigned DIV/REM with valid/data_ok handshake
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             data_ok,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rpart, dvd, mb, la, lb, diff, nrem, ndvd;
    logic [WIDTH:0] shifted;
    logic ls, sa, sb, borrow, ge, last, same;
    always_comb begin
        shifted = {rpart, dvd[WIDTH-1]};
        // shifted[WIDTH] set means the shifted remainder already exceeds any divisor magnitude
        {borrow, diff} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, mb};
        ge = shifted[WIDTH] | ~borrow;
        nrem = ge ? diff : shifted[WIDTH-1:0];
        ndvd = {dvd[WIDTH-2:0], ge};
        last = cnt == CW'(WIDTH-1);
        same = valid && a == la && b == lb && is_signed == ls;
        next = state == IDLE ? (valid ? (b == '0 ? DONE : BUSY) : IDLE) :
               state == BUSY ? (!valid ? IDLE : (last ? DONE : BUSY)) :
               (state == DONE && same) ? DONE : IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            rpart <= '0;
            dvd <= '0;
            mb <= '0;
            la <= '0;
            lb <= '0;
            ls <= 1'b0;
            sa <= 1'b0;
            sb <= 1'b0;
            quot <= '0;
            rem <= '0;
        end else if (state == IDLE && valid) begin
            la <= a;
            lb <= b;
            ls <= is_signed;
            sa <= is_signed & a[WIDTH-1];
            sb <= is_signed & b[WIDTH-1];
            dvd <= (is_signed && a[WIDTH-1]) ? -a : a;
            mb <= (is_signed && b[WIDTH-1]) ? -b : b;
            rpart <= '0;
            cnt <= '0;
            if (b == '0) begin
                quot <= '1;
                rem <= a;
            end
        end else if (state == BUSY) begin
            rpart <= nrem;
            dvd <= ndvd;
            cnt <= cnt + 1'b1;
            if (valid && last) begin
                quot <= (sa ^ sb) ? -ndvd : ndvd;
                rem <= sa ? -nrem : nrem;
            end
        end
    end
    assign busy = state == BUSY;
    assign data_ok = state == DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider with hand-computed results and latencies
module tb_seq_divider;
    logic clk = 1'b0;
    logic reset, valid, is_signed, data_ok, busy;
    logic [63:0] a, b, quot, rem;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk(clk), .reset(reset), .valid(valid), .is_signed(is_signed),
        .a(a), .b(b), .quot(quot), .rem(rem), .data_ok(data_ok), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_ok(output int lat, output int nbusy, output int both);
        lat = 0;
        nbusy = 0;
        both = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) nbusy++;
            if (busy && data_ok) both++;
        end while (!data_ok && lat < 200);
    endtask

    task automatic run(input string tag, input logic s, input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] eq, input logic [63:0] er, input int elat);
        int lat, nb, bo;
        is_signed = s;
        a = x;
        b = y;
        valid = 1'b1;
        wait_ok(lat, nb, bo);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_busycyc"}, 64'(nb), 64'(elat - 1));
        check({tag, "_both"}, 64'(bo), 64'd0);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_release"}, 64'(data_ok), 64'd0);
    endtask

    initial begin
        int lat, nb, bo;
        reset = 1'b1;
        valid = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quot", quot, 64'd0);
        check("rst_rem", rem, 64'd0);
        check("rst_ok", 64'(data_ok), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        run("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
        run("sm7_2", 1'b1, -64'd7, 64'd2, -64'd3, -64'd1, 65);
        run("s7_m2", 1'b1, 64'd7, -64'd2, -64'd3, 64'd1, 65);
        run("umax_2", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65);
        run("sdiv0", 1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
        run("udiv0", 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
        run("smin_m1", 1'b1, 64'h8000_0000_0000_0000, -64'd1, 64'h8000_0000_0000_0000, 64'd0, 65);

        is_signed = 1'b0;
        a = 64'd100;
        b = 64'd7;
        valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_busy30", 64'(busy), 64'd1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy31", 64'(busy), 64'd0);
        check("abort_ok31", 64'(data_ok), 64'd0);
        @(posedge clk);
        #1;
        check("abort_ok32", 64'(data_ok), 64'd0);
        run("reissue9_3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

        a = 64'd100;
        b = 64'd7;
        valid = 1'b1;
        repeat (20) @(posedge clk);
        #4;
        reset = 1'b1;
        valid = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ok", 64'(data_ok), 64'd0);
        check("mid_rst_quot", quot, 64'd0);
        check("mid_rst_rem", rem, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        a = 64'd50;
        b = 64'd6;
        valid = 1'b1;
        wait_ok(lat, nb, bo);
        check("hold_lat", 64'(lat), 64'd65);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_ok", 64'(data_ok), 64'd1);
            check("hold_quot", quot, 64'd8);
            check("hold_rem", rem, 64'd2);
        end
        b = 64'd5;
        @(posedge clk);
        #1;
        check("chg_ok_drop", 64'(data_ok), 64'd0);
        wait_ok(lat, nb, bo);
        check("chg_lat", 64'(lat + 1), 64'd66);
        check("chg_quot", quot, 64'd10);
        check("chg_rem", rem, 64'd0);
        valid = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
